// File: rtl/lfsr_seq_pkg.sv
// Shared definitions for the LFSR sequencer.
//   seq_state_t     : sequencer FSM states
//   LFSR_WIDTH      : default LFSR length
//   LFSR_TAPS       : default feedback mask (x^6 + x^5 + 1, period 63)
//   LFSR_RESET_SEED : default post-reset LFSR state (nonzero)
package lfsr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int             LFSR_WIDTH      = 6;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS       = 6'b110000;
    localparam logic [LFSR_WIDTH-1:0] LFSR_RESET_SEED = 6'b000001;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with load and step controls.
//   clk      : clock, posedge
//   reset    : synchronous active-high; state <= RESET_SEED
//   load     : load load_val (priority over step)
//   load_val : value to load
//   step     : advance one position
//   state    : current register, s[0] newest, s[WIDTH-1] oldest
//   bit_out  : bit emitted by the next step (oldest bit)
module lfsr_core #(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] TAPS       = 6'b110000,
    parameter logic [WIDTH-1:0] RESET_SEED = 6'b000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic             bit_out
);

    logic feedback;

    assign feedback = ^(state & TAPS);
    assign bit_out  = state[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_sequencer.sv
// On-demand LFSR bit-burst generator.
// A client loads a seed (IDLE only), then requests 1..OUT_W bits. The LFSR
// is stepped exactly that many times, the emitted bits are packed LSB-first
// into out_data and returned over a valid/ready handshake. The LFSR is frozen
// between requests so sequences are reproducible.
//   clk, reset  : clock / synchronous active-high reset
//   seed_load   : load seed (IDLE only, zero seed rejected)
//   seed        : seed value
//   req         : request a burst (IDLE only, loses to seed_load)
//   req_len     : burst length, 0 means OUT_W
//   out_valid   : result available (DONE)
//   out_ready   : consumer accepts result
//   out_data    : packed bits, first generated bit in bit 0
//   busy        : state != IDLE
//   seed_err    : one-cycle pulse after a zero seed was rejected
//   lfsr_state  : current LFSR register (debug)
module lfsr_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int               WIDTH      = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS,
    parameter logic [WIDTH-1:0] RESET_SEED = LFSR_RESET_SEED,
    parameter int               OUT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         seed_load,
    input  logic [WIDTH-1:0]             seed,
    input  logic                         req,
    input  logic [$clog2(OUT_W+1)-1:0]   req_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         busy,
    output logic                         seed_err,
    output logic [WIDTH-1:0]             lfsr_state
);

    localparam int LEN_W = $clog2(OUT_W+1);

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  data_q;
    logic              err_q;

    logic              lfsr_load;
    logic              lfsr_step;
    logic              lfsr_bit;
    logic              seed_zero;
    logic              req_take;
    logic              last_step;

    assign seed_zero = (seed == '0);
    assign lfsr_load = (state_q == IDLE) && seed_load && !seed_zero;
    assign lfsr_step = (state_q == RUN);
    assign req_take  = (state_q == IDLE) && !seed_load && req;
    assign last_step = (cnt_q == len_q - LEN_W'(1));

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (seed),
        .step     (lfsr_step),
        .state    (lfsr_state),
        .bit_out  (lfsr_bit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_take) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && seed_load && seed_zero;
            if (req_take) begin
                // 0 (and any out-of-range code) selects a full OUT_W burst
                if (req_len == '0 || req_len > LEN_W'(OUT_W))
                    len_q <= LEN_W'(OUT_W);
                else
                    len_q <= req_len;
                cnt_q  <= '0;
                data_q <= '0;
            end else if (state_q == RUN) begin
                // shift-based insert keeps the bit position at cnt without a
                // narrow index into data_q
                data_q <= data_q | ({{(OUT_W-1){1'b0}}, lfsr_bit} << cnt_q);
                cnt_q  <= cnt_q + LEN_W'(1);
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Self-checking bench for lfsr_sequencer: directed scenarios plus randomized
// requests checked against a transaction-level LFSR model.
module tb_lfsr_sequencer;

    localparam int WIDTH = 6;
    localparam int OUT_W = 8;
    localparam logic [WIDTH-1:0] TAPS = 6'b110000;

    logic             clk = 1'b0;
    logic             reset;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             req;
    logic [3:0]       req_len;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic             seed_err;
    logic [WIDTH-1:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_lfsr;      // model LFSR contents
    logic [OUT_W-1:0] m_word;      // model result of last request

    lfsr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .req        (req),
        .req_len    (req_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .seed_err   (seed_err),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: emitted bit is the oldest bit, new bit is the parity of tapped bits.
    function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] s);
        int par;
        par = $countones(s & TAPS) % 2;
        return WIDTH'((int'(s) * 2 + par) % (1 << WIDTH));
    endfunction

    // Produce the expected word for a burst of n bits and advance the model.
    function automatic logic [OUT_W-1:0] model_burst(input int n);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (int'(m_lfsr) >= (1 << (WIDTH-1))) w = w + OUT_W'(1 << i);
            m_lfsr = model_next(m_lfsr);
        end
        return w;
    endfunction

    // One request: req_len code, stall cycles in DONE with out_ready low.
    task automatic run_req(input int code, input int stall, input string tag);
        int n;
        logic [OUT_W-1:0] held_data;
        logic [WIDTH-1:0] held_state;
        n = (code == 0) ? OUT_W : code;
        m_word = model_burst(n);
        req = 1'b1; req_len = 4'(code); out_ready = 1'b0;
        tick();                              // E0
        req = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        for (int k = 1; k <= n; k++) begin
            // inputs ignored in RUN
            seed_load = 1'($urandom_range(0, 1));
            seed = 6'($urandom);
            req  = 1'($urandom_range(0, 1));
            tick();
            chk({tag, "_nonzero"}, 32'(lfsr_state != 0), 32'd1);
            if (k < n) chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        end
        seed_load = 1'b0; req = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(m_word));
        chk({tag, "_lfsr"}, 32'(lfsr_state), 32'(m_lfsr));
        held_data = out_data; held_state = lfsr_state;
        for (int k = 0; k < stall; k++) begin
            seed_load = 1'($urandom_range(0, 1));
            seed = 6'($urandom_range(0, 1) ? 0 : $urandom);
            req  = 1'($urandom_range(0, 1));
            tick();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_data"}, 32'(out_data), 32'(held_data));
            chk({tag, "_stall_lfsr"}, 32'(lfsr_state), 32'(held_state));
            chk({tag, "_stall_err"}, 32'(seed_err), 32'd0);
        end
        // handshake edge; a req here must be ignored
        seed_load = 1'b0; out_ready = 1'b1; req = 1'b1;
        tick();
        out_ready = 1'b0; req = 1'b0;
        chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_bubble_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; seed_load = 1'b0; seed = '0; req = 1'b0;
        req_len = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        m_lfsr = 6'b000001;
        chk("rst_lfsr", 32'(lfsr_state), 32'h01);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(seed_err), 32'd0);

        // 1: len 6 from reset seed
        run_req(6, 0, "s1");
        chk("s1_word", 32'(m_word), 32'h20);
        chk("s1_state", 32'(m_lfsr), 32'h03);
        // 2: len code 0 means 8
        run_req(0, 0, "s2");
        chk("s2_word", 32'(m_word), 32'h30);
        chk("s2_state", 32'(m_lfsr), 32'h14);

        // 3: full period 63 = 9 x 7
        seed_load = 1'b1; seed = 6'b000001;
        tick();
        seed_load = 1'b0;
        m_lfsr = 6'b000001;
        chk("s3_load", 32'(lfsr_state), 32'h01);
        for (int i = 0; i < 9; i++) run_req(7, 0, "s3");
        chk("s3_period", 32'(lfsr_state), 32'h01);

        // 4: zero seed rejected, then seed_load beats req
        seed_load = 1'b1; seed = '0;
        tick();
        seed_load = 1'b0;
        chk("s4_err_pulse", 32'(seed_err), 32'd1);
        chk("s4_err_lfsr", 32'(lfsr_state), 32'(m_lfsr));
        tick();
        chk("s4_err_clear", 32'(seed_err), 32'd0);
        seed_load = 1'b1; req = 1'b1; req_len = 4'd3; seed = 6'b101010;
        tick();
        seed_load = 1'b0; req = 1'b0;
        m_lfsr = 6'b101010;
        chk("s4_seed", 32'(lfsr_state), 32'h2a);
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_noerr", 32'(seed_err), 32'd0);
        tick();
        chk("s4_busy2", 32'(busy), 32'd0);

        // 5: backpressure
        run_req(4, 5, "s5");

        // randomized requests, seeds and stalls
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                seed_load = 1'b1;
                seed = 6'($urandom_range(1, 63));
                tick();
                seed_load = 1'b0;
                m_lfsr = seed;
                chk("rnd_seed", 32'(lfsr_state), 32'(m_lfsr));
            end
            run_req(int'($urandom_range(0, OUT_W)), int'($urandom_range(0, 3)), "rnd");
        end

        // 6: reset on the 3rd step of a len-8 run
        req = 1'b1; req_len = 4'd8;
        tick();                              // E0
        req = 1'b0;
        tick();                              // step 1
        tick();                              // step 2
        reset = 1'b1;
        tick();                              // E3 with reset
        reset = 1'b0;
        m_lfsr = 6'b000001;
        chk("s6_valid", 32'(out_valid), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_data", 32'(out_data), 32'd0);
        chk("s6_lfsr", 32'(lfsr_state), 32'h01);
        tick();
        chk("s6_idle_hold", 32'(lfsr_state), 32'h01);
        run_req(6, 0, "s6_after");
        chk("s6_after_word", 32'(out_data), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
